// File: rtl/phy_rx_lane_merge_if.sv
// Lane-side bundle for the two-lane receive merger: per-lane symbols in,
// merged words and link status out.
interface phy_rx_lane_merge_if;
  logic [7:0]  data_in_0;
  logic [7:0]  data_in_1;
  logic        valid_in_0;
  logic        valid_in_1;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active_out;
  logic        lane_error;

  modport master (
    output data_in_0, data_in_1, valid_in_0, valid_in_1,
    input  data_out, valid_out, active_out, lane_error
  );

  modport slave (
    input  data_in_0, data_in_1, valid_in_0, valid_in_1,
    output data_out, valid_out, active_out, lane_error
  );
endinterface

// File: rtl/phy_rx_lane_merge.sv
// Two-lane PHY receiver: per-lane COM symbol lock, then merges two beats of
// byte pairs into one 32-bit word for the link layer.
module phy_rx_lane_merge #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input logic                clk_2f,
  input logic                reset,
  phy_rx_lane_merge_if.slave lane_if
);

  localparam logic [3:0] SyncCnt = 4'(SYNC_COUNT);

  typedef enum logic {LnHunt, LnLocked} lane_st_e;
  typedef enum logic {MgIdle, MgHalf}   merge_st_e;

  lane_st_e    r_lane_st [2];
  lane_st_e    w_lane_st_nxt [2];
  logic [3:0]  r_cnt [2];
  logic [3:0]  w_cnt_nxt [2];
  logic [7:0]  w_data [2];
  logic [1:0]  w_valid;
  logic [1:0]  w_sym_com;
  logic [1:0]  w_loss;

  merge_st_e   r_mg, w_mg_nxt;
  logic [7:0]  r_hi0, r_hi1, w_hi0_nxt, w_hi1_nxt;
  logic [31:0] r_data_out, w_data_nxt;
  logic        r_valid_out, w_valid_nxt;
  logic        r_active, r_lane_error;
  logic        w_both_locked, w_run, w_mismatch;

  assign w_data[0]    = lane_if.data_in_0;
  assign w_data[1]    = lane_if.data_in_1;
  assign w_valid      = {lane_if.valid_in_1, lane_if.valid_in_0};
  assign w_sym_com[0] = (lane_if.data_in_0 == COM_SYMBOL);
  assign w_sym_com[1] = (lane_if.data_in_1 == COM_SYMBOL);

  assign w_both_locked = (r_lane_st[0] == LnLocked) && (r_lane_st[1] == LnLocked);
  // Gate on the live lane states too: active_out lags a lock loss by one cycle.
  assign w_run         = r_active && w_both_locked;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_lane_st_nxt[i] = r_lane_st[i];
      w_cnt_nxt[i]     = r_cnt[i];
      w_loss[i]        = 1'b0;
      case (r_lane_st[i])
        LnHunt: begin
          if (!w_valid[i] && w_sym_com[i]) begin
            if ((r_cnt[i] + 4'd1) == SyncCnt) begin
              w_lane_st_nxt[i] = LnLocked;
              w_cnt_nxt[i]     = 4'd0;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + 4'd1;
            end
          end else begin
            w_cnt_nxt[i] = 4'd0;
          end
        end
        LnLocked: begin
          if (!w_valid[i] && !w_sym_com[i]) begin
            w_lane_st_nxt[i] = LnHunt;
            w_cnt_nxt[i]     = 4'd0;
            w_loss[i]        = 1'b1;
          end
        end
        default: begin
          w_lane_st_nxt[i] = LnHunt;
          w_cnt_nxt[i]     = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_mg_nxt    = r_mg;
    w_hi0_nxt   = r_hi0;
    w_hi1_nxt   = r_hi1;
    w_data_nxt  = r_data_out;
    w_valid_nxt = 1'b0;
    w_mismatch  = 1'b0;
    if (!w_run || (|w_loss)) begin
      w_mg_nxt  = MgIdle;
      w_hi0_nxt = 8'd0;
      w_hi1_nxt = 8'd0;
    end else if (&w_valid) begin
      if (r_mg == MgIdle) begin
        w_mg_nxt  = MgHalf;
        w_hi0_nxt = w_data[0];
        w_hi1_nxt = w_data[1];
      end else begin
        w_mg_nxt    = MgIdle;
        w_data_nxt  = {r_hi0, r_hi1, w_data[0], w_data[1]};
        w_valid_nxt = 1'b1;
        w_hi0_nxt   = 8'd0;
        w_hi1_nxt   = 8'd0;
      end
    end else if (^w_valid) begin
      w_mismatch = 1'b1;
      w_mg_nxt   = MgIdle;
      w_hi0_nxt  = 8'd0;
      w_hi1_nxt  = 8'd0;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_lane_st[i] <= LnHunt;
        r_cnt[i]     <= 4'd0;
      end
      r_mg         <= MgIdle;
      r_hi0        <= 8'd0;
      r_hi1        <= 8'd0;
      r_data_out   <= 32'd0;
      r_valid_out  <= 1'b0;
      r_active     <= 1'b0;
      r_lane_error <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_lane_st[i] <= w_lane_st_nxt[i];
        r_cnt[i]     <= w_cnt_nxt[i];
      end
      r_mg         <= w_mg_nxt;
      r_hi0        <= w_hi0_nxt;
      r_hi1        <= w_hi1_nxt;
      r_data_out   <= w_data_nxt;
      r_valid_out  <= w_valid_nxt;
      r_active     <= w_both_locked;
      r_lane_error <= (|w_loss) | w_mismatch;
    end
  end

  assign lane_if.data_out   = r_data_out;
  assign lane_if.valid_out  = r_valid_out;
  assign lane_if.active_out = r_active;
  assign lane_if.lane_error = r_lane_error;

endmodule

// File: tb/tb_phy_rx_lane_merge.sv
// Self-checking bench for phy_rx_lane_merge: directed vector table, corner
// sequences, then random traffic against a queue-based reference model.
module tb_phy_rx_lane_merge;

  localparam logic [7:0] COM  = 8'hBC;
  localparam int         SYNC = 4;

  logic clk_2f;
  logic reset;
  phy_rx_lane_merge_if u_if ();

  phy_rx_lane_merge #(
    .COM_SYMBOL (COM),
    .SYNC_COUNT (SYNC)
  ) u_dut (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .lane_if (u_if)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_cnt [2];
  bit          m_lock [2];
  bit          m_active;
  logic [15:0] m_beats [$];
  logic [31:0] m_data;
  bit          m_vout;
  bit          m_err;

  typedef struct {
    logic        rst;
    logic        v0;
    logic        v1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        exp_vout;
    logic        exp_act;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit v0, input bit v1,
                            input logic [7:0] d0, input logic [7:0] d1);
    bit          v [2];
    logic [7:0]  d [2];
    bit          loss [2];
    bit          run;
    bit          mism;
    bit          new_active;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i]  = 0;
        m_lock[i] = 0;
      end
      m_active = 0;
      m_beats.delete();
      m_data = 32'd0;
      m_vout = 0;
      m_err  = 0;
      return;
    end
    v[0] = v0; v[1] = v1; d[0] = d0; d[1] = d1;
    for (int i = 0; i < 2; i++) loss[i] = m_lock[i] && !v[i] && (d[i] != COM);
    run    = m_active && m_lock[0] && m_lock[1];
    m_vout = 0;
    mism   = 0;
    if (!run || loss[0] || loss[1]) begin
      m_beats.delete();
    end else if (v0 && v1) begin
      m_beats.push_back({d0, d1});
      if (m_beats.size() == 2) begin
        m_data = {m_beats[0], m_beats[1]};
        m_vout = 1;
        m_beats.delete();
      end
    end else if (v0 != v1) begin
      mism = 1;
      m_beats.delete();
    end
    m_err      = loss[0] || loss[1] || mism;
    new_active = m_lock[0] && m_lock[1];
    for (int i = 0; i < 2; i++) begin
      if (!m_lock[i]) begin
        if (!v[i] && d[i] == COM) begin
          m_cnt[i]++;
          if (m_cnt[i] == SYNC) begin
            m_lock[i] = 1;
            m_cnt[i]  = 0;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end else if (loss[i]) begin
        m_lock[i] = 0;
        m_cnt[i]  = 0;
      end
    end
    m_active = new_active;
  endtask

  task automatic step(input bit rst, input bit v0, input bit v1,
                      input logic [7:0] d0, input logic [7:0] d1);
    reset           = rst;
    u_if.valid_in_0 = v0;
    u_if.valid_in_1 = v1;
    u_if.data_in_0  = d0;
    u_if.data_in_1  = d1;
    model_step(rst, v0, v1, d0, d1);
    @(posedge clk_2f);
    #1;
    chk("model_valid_out", {31'd0, u_if.valid_out}, {31'd0, m_vout});
    chk("model_active_out", {31'd0, u_if.active_out}, {31'd0, m_active});
    chk("model_lane_error", {31'd0, u_if.lane_error}, {31'd0, m_err});
    chk("model_data_out", u_if.data_out, m_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, COM, COM);
  endtask

  task automatic expect_word(input logic [31:0] exp);
    chk("word_valid", {31'd0, u_if.valid_out}, 32'd1);
    chk("word_data", u_if.data_out, exp);
  endtask

  task automatic expect_none();
    chk("no_word", {31'd0, u_if.valid_out}, 32'd0);
  endtask

  initial begin
    int         r;
    logic [7:0] a;
    logic [7:0] b;

    reset           = 1'b1;
    u_if.valid_in_0 = 1'b0;
    u_if.valid_in_1 = 1'b0;
    u_if.data_in_0  = COM;
    u_if.data_in_1  = COM;

    // rst v0 v1 d0 d1 | vout act err data
    vecs[0]  = '{1'b1, 1'b0, 1'b0, COM,   COM,   1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, COM,   COM,   1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, COM,   COM,   1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, COM,   COM,   1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, COM,   COM,   1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, COM,   COM,   1'b0, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'hDE, 8'hAD, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'hBE, 8'hEF, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, COM,   COM,   1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h12, COM,   1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 1'b0, 1'b0, COM,   COM,   1'b0, 1'b1, 1'b0, 32'hDEADBEEF};

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].rst, vecs[i].v0, vecs[i].v1, vecs[i].d0, vecs[i].d1);
      chk("vec_valid_out", {31'd0, u_if.valid_out}, {31'd0, vecs[i].exp_vout});
      chk("vec_active_out", {31'd0, u_if.active_out}, {31'd0, vecs[i].exp_act});
      chk("vec_lane_error", {31'd0, u_if.lane_error}, {31'd0, vecs[i].exp_err});
      chk("vec_data_out", u_if.data_out, vecs[i].exp_data);
    end

    // Back-to-back words, then a word with a 3-cycle gap between beats
    step(0, 1, 1, 8'h01, 8'h23);
    step(0, 1, 1, 8'h45, 8'h67); expect_word(32'h01234567);
    step(0, 1, 1, 8'h89, 8'hAB); expect_none();
    step(0, 1, 1, 8'hCD, 8'hEF); expect_word(32'h89ABCDEF);
    step(0, 1, 1, 8'hCA, 8'hFE); expect_none();
    idle(3);                     expect_none();
    step(0, 1, 1, 8'hF0, 8'h0D); expect_word(32'hCAFEF00D);
    idle(1);                     expect_none();

    // Single-lane valid while holding a half word
    step(0, 1, 1, 8'h55, 8'h66);
    step(0, 1, 0, 8'h77, COM);
    chk("half_mismatch_err", {31'd0, u_if.lane_error}, 32'd1);
    expect_none();
    idle(1);
    chk("half_mismatch_err_clear", {31'd0, u_if.lane_error}, 32'd0);
    step(0, 1, 1, 8'h11, 8'h22);
    step(0, 1, 1, 8'h33, 8'h44); expect_word(32'h11223344);

    // Lane 1 loses lock, then relocks after SYNC COMs
    step(0, 0, 0, COM, 8'h00);
    chk("loss_err", {31'd0, u_if.lane_error}, 32'd1);
    chk("loss_active_lag", {31'd0, u_if.active_out}, 32'd1);
    idle(1);
    chk("loss_active_fall", {31'd0, u_if.active_out}, 32'd0);
    idle(2);
    chk("relock_3com", {31'd0, u_if.active_out}, 32'd0);
    idle(2);
    chk("relock_active", {31'd0, u_if.active_out}, 32'd1);

    // Reset between beats of AABBCCDD
    step(0, 1, 1, 8'hAA, 8'hBB);
    step(1, 1, 1, 8'hCC, 8'hDD);
    chk("rst_valid_out", {31'd0, u_if.valid_out}, 32'd0);
    chk("rst_active_out", {31'd0, u_if.active_out}, 32'd0);
    chk("rst_lane_error", {31'd0, u_if.lane_error}, 32'd0);
    chk("rst_data_out", u_if.data_out, 32'd0);
    idle(5);
    chk("rst_relock", {31'd0, u_if.active_out}, 32'd1);
    step(0, 1, 1, 8'hCC, 8'hDD); expect_none();
    idle(2);                     expect_none();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      a = 8'($urandom);
      b = 8'($urandom);
      if (!(m_active && m_lock[0] && m_lock[1])) begin
        if (r < 3) step(0, 0, 0, COM, (b == COM) ? 8'h00 : b);
        else if (r < 6) step(0, 1, 1, a, b);
        else idle(1);
      end else if (r < 1) begin
        step(1, 0, 0, COM, COM);
      end else if (r < 60) begin
        step(0, 1, 1, a, b);
      end else if (r < 88) begin
        idle(1);
      end else if (r < 93) begin
        step(0, 1, 0, a, COM);
      end else if (r < 98) begin
        step(0, 0, 1, COM, b);
      end else if (r[0]) begin
        step(0, 0, 0, (a == COM) ? 8'h00 : a, COM);
      end else begin
        step(0, 1, 0, a, (b == COM) ? 8'h00 : b);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
